// File: rtl/anabellek_denetleyici_pkg.sv
// Shared definitions for the main-memory responder: state encoding, requester IDs,
// beat-count derivation and the block-offset width.
package anabellek_paket;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    TAMAM = 2'd3
  } durum_t;

  localparam logic ISTEKCI_GETIR  = 1'b0;
  localparam logic ISTEKCI_BELLEK = 1'b1;

  // Byte-offset bits inside one block; forced to zero when an address is latched.
  localparam int OBEK_OFSET_BIT = 4;

  function automatic int vurus_sayisi(input int obek_bit, input int veri_bit);
    return obek_bit / veri_bit;
  endfunction

endpackage

// File: rtl/anabellek_denetleyici_hakem.sv
// Two-input arbiter for the fetch and memory-stage requesters.
// ANABELLEK_ADIL_HAKEM_EN selects round-robin; otherwise bellek has fixed priority.
module anabellek_hakem
  import anabellek_paket::*;
(
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_etkin,
  input  logic i_getir_istek,
  input  logic i_bellek_istek,
  output logic o_gecerli,
  output logic o_kimlik
);

  assign o_gecerli = i_etkin & (i_getir_istek | i_bellek_istek);

`ifdef ANABELLEK_ADIL_HAKEM_EN
  logic r_son_verilen;

  // On contention the requester that did not win last time is served.
  always_comb begin
    o_kimlik = ISTEKCI_GETIR;
    if (i_getir_istek && i_bellek_istek) begin
      o_kimlik = ~r_son_verilen;
    end else if (i_bellek_istek) begin
      o_kimlik = ISTEKCI_BELLEK;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_son_verilen <= ISTEKCI_GETIR;
    end else if (o_gecerli) begin
      r_son_verilen <= o_kimlik;
    end
  end
`else
  logic w_unused_saat;

  assign o_kimlik      = i_bellek_istek ? ISTEKCI_BELLEK : ISTEKCI_GETIR;
  assign w_unused_saat = i_clk ^ i_srst;
`endif

endmodule

// File: rtl/anabellek_denetleyici.sv
// Main-memory responder: serves 128-bit block reads/writes from fetch and memory stage
// as 32-bit beats on the word bus. Optional round-robin arbitration: ANABELLEK_ADIL_HAKEM_EN.
module anabellek_denetleyici
  import anabellek_paket::*;
#(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32,
  parameter int OBEK_BIT  = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 getir_istek_i,
  input  logic [ADRES_BIT-1:0] getir_adres_i,
  input  logic                 getir_oku_i,
  input  logic                 getir_yaz_i,
  output logic                 getir_veri_hazir_o,
  output logic [OBEK_BIT-1:0]  getir_obek_o,
  input  logic                 bellek_istek_i,
  input  logic [ADRES_BIT-1:0] bellek_adres_i,
  input  logic                 bellek_yaz_i,
  input  logic [OBEK_BIT-1:0]  bellek_yazilacak_obek_i,
  output logic                 bellek_veri_hazir_o,
  output logic [OBEK_BIT-1:0]  bellek_obek_o,
  output logic                 anabellek_musait_o,
  output logic                 ab_gecerli_o,
  input  logic                 ab_hazir_i,
  output logic                 ab_yaz_o,
  output logic [ADRES_BIT-1:0] ab_adres_o,
  output logic [VERI_BIT-1:0]  ab_yaz_veri_o,
  input  logic                 ab_oku_gecerli_i,
  input  logic [VERI_BIT-1:0]  ab_oku_veri_i
);

  localparam int VURUS       = vurus_sayisi(OBEK_BIT, VERI_BIT);
  localparam int VURUS_BIT   = (VURUS > 1) ? $clog2(VURUS) : 1;
  localparam int BAYT_KAYDIR = $clog2(VERI_BIT / 8);
  localparam logic [VURUS_BIT-1:0] SON_VURUS = VURUS_BIT'(VURUS - 1);

  durum_t                 r_durum;
  durum_t                 w_durum_next;
  logic [VURUS_BIT-1:0]   r_vurus;
  logic                   r_kimlik;
  logic [ADRES_BIT-1:0]   r_adres;
  logic                   r_yaz;
  logic [OBEK_BIT-1:0]    r_yaz_obek;
  logic [OBEK_BIT-1:0]    r_obek;

  logic                   w_hakem_gecerli;
  logic                   w_hakem_kimlik;
  logic                   w_son_vurus;
  logic [ADRES_BIT-1:0]   w_secili_adres;
  logic                   w_unused_girisler;

  anabellek_hakem u_hakem (
    .i_clk          (clk_i),
    .i_srst         (rst_i),
    .i_etkin        (r_durum == BOSTA),
    .i_getir_istek  (getir_istek_i),
    .i_bellek_istek (bellek_istek_i),
    .o_gecerli      (w_hakem_gecerli),
    .o_kimlik       (w_hakem_kimlik)
  );

  assign w_son_vurus    = (r_vurus == SON_VURUS);
  assign w_secili_adres = (w_hakem_kimlik == ISTEKCI_BELLEK) ? bellek_adres_i : getir_adres_i;

  // The fetch port is read-only and block offsets are discarded on latch.
  assign w_unused_girisler = ^{getir_oku_i, getir_yaz_i, w_secili_adres[OBEK_OFSET_BIT-1:0]};

  assign getir_obek_o  = r_obek;
  assign bellek_obek_o = r_obek;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_durum_next;
    end
  end

  always_comb begin
    w_durum_next        = r_durum;
    anabellek_musait_o  = 1'b0;
    ab_gecerli_o        = 1'b0;
    ab_yaz_o            = 1'b0;
    ab_adres_o          = '0;
    ab_yaz_veri_o       = '0;
    getir_veri_hazir_o  = 1'b0;
    bellek_veri_hazir_o = 1'b0;
    unique case (r_durum)
      BOSTA: begin
        anabellek_musait_o = 1'b1;
        if (w_hakem_gecerli) begin
          w_durum_next = ISTEK;
        end
      end
      ISTEK: begin
        ab_gecerli_o = 1'b1;
        ab_yaz_o     = r_yaz;
        ab_adres_o   = r_adres | (ADRES_BIT'(r_vurus) << BAYT_KAYDIR);
        if (r_yaz) begin
          ab_yaz_veri_o = r_yaz_obek[r_vurus*VERI_BIT +: VERI_BIT];
        end
        if (ab_hazir_i) begin
          if (!r_yaz) begin
            w_durum_next = BEKLE;
          end else if (w_son_vurus) begin
            w_durum_next = TAMAM;
          end
        end
      end
      BEKLE: begin
        if (ab_oku_gecerli_i) begin
          w_durum_next = w_son_vurus ? TAMAM : ISTEK;
        end
      end
      TAMAM: begin
        getir_veri_hazir_o  = (r_kimlik == ISTEKCI_GETIR);
        bellek_veri_hazir_o = (r_kimlik == ISTEKCI_BELLEK);
        w_durum_next        = BOSTA;
      end
      default: w_durum_next = BOSTA;
    endcase
  end

  // Request fields are captured once at grant so requesters may change or drop them later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vurus    <= '0;
      r_kimlik   <= ISTEKCI_GETIR;
      r_adres    <= '0;
      r_yaz      <= 1'b0;
      r_yaz_obek <= '0;
      r_obek     <= '0;
    end else begin
      unique case (r_durum)
        BOSTA: begin
          if (w_hakem_gecerli) begin
            r_kimlik   <= w_hakem_kimlik;
            r_adres    <= {w_secili_adres[ADRES_BIT-1:OBEK_OFSET_BIT], {OBEK_OFSET_BIT{1'b0}}};
            r_yaz      <= (w_hakem_kimlik == ISTEKCI_BELLEK) & bellek_yaz_i;
            r_yaz_obek <= bellek_yazilacak_obek_i;
            r_vurus    <= '0;
          end
        end
        ISTEK: begin
          if (ab_hazir_i && r_yaz && !w_son_vurus) begin
            r_vurus <= r_vurus + 1'b1;
          end
        end
        BEKLE: begin
          if (ab_oku_gecerli_i) begin
            r_obek[r_vurus*VERI_BIT +: VERI_BIT] <= ab_oku_veri_i;
            if (!w_son_vurus) begin
              r_vurus <= r_vurus + 1'b1;
            end
          end
        end
        TAMAM: begin
          r_vurus <= '0;
        end
        default: r_vurus <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Self-checking bench for anabellek_denetleyici: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literals.
module tb_anabellek_denetleyici;

`ifdef ANABELLEK_ADIL_HAKEM_EN
  localparam bit ADIL = 1'b1;
`else
  localparam bit ADIL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i;
  logic         getir_istek_i, getir_oku_i, getir_yaz_i;
  logic [31:0]  getir_adres_i;
  logic         getir_veri_hazir_o;
  logic [127:0] getir_obek_o;
  logic         bellek_istek_i, bellek_yaz_i;
  logic [31:0]  bellek_adres_i;
  logic [127:0] bellek_yazilacak_obek_i;
  logic         bellek_veri_hazir_o;
  logic [127:0] bellek_obek_o;
  logic         anabellek_musait_o;
  logic         ab_gecerli_o, ab_hazir_i, ab_yaz_o;
  logic [31:0]  ab_adres_o, ab_yaz_veri_o;
  logic         ab_oku_gecerli_i;
  logic [31:0]  ab_oku_veri_i;

  always #5 clk = ~clk;

  anabellek_denetleyici dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .getir_istek_i           (getir_istek_i),
    .getir_adres_i           (getir_adres_i),
    .getir_oku_i             (getir_oku_i),
    .getir_yaz_i             (getir_yaz_i),
    .getir_veri_hazir_o      (getir_veri_hazir_o),
    .getir_obek_o            (getir_obek_o),
    .bellek_istek_i          (bellek_istek_i),
    .bellek_adres_i          (bellek_adres_i),
    .bellek_yaz_i            (bellek_yaz_i),
    .bellek_yazilacak_obek_i (bellek_yazilacak_obek_i),
    .bellek_veri_hazir_o     (bellek_veri_hazir_o),
    .bellek_obek_o           (bellek_obek_o),
    .anabellek_musait_o      (anabellek_musait_o),
    .ab_gecerli_o            (ab_gecerli_o),
    .ab_hazir_i              (ab_hazir_i),
    .ab_yaz_o                (ab_yaz_o),
    .ab_adres_o              (ab_adres_o),
    .ab_yaz_veri_o           (ab_yaz_veri_o),
    .ab_oku_gecerli_i        (ab_oku_gecerli_i),
    .ab_oku_veri_i           (ab_oku_veri_i)
  );

  int n_karsilastirma = 0;
  int n_hata = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
    n_karsilastirma++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s @cyc %0d: got %h expected %h", ad, cyc, gercek, beklenen);
    end
  endtask

  // Memory contents: word k of a block is k+1 repeated, xor the upper address half.
  function automatic logic [31:0] bellek_kelime(input logic [31:0] a);
    logic [3:0] n;
    n = 4'(a[3:2]) + 4'd1;
    return {8{n}} ^ {a[31:16], 16'h0};
  endfunction

  // ---------------- transaction-level model ----------------
  bit           m_mesgul = 0, m_bekle = 0, m_bitti = 0, m_kim = 0, m_son = 0, m_yaz = 0;
  int           m_vurus = 0;
  logic [31:0]  m_taban = '0;
  logic [127:0] m_wobek = '0, m_obek = '0;

  // logs
  logic [31:0]  q_adres[$], q_yveri[$];
  int           q_kim[$], q_cyc[$];
  int           g_cnt = 0, b_cnt = 0;

  // word-bus responder state
  bit           rd_pending = 0, spur = 0;
  logic [31:0]  rd_adres = '0;
  int           stall_beat = -1, stall_len = 0, stall_used = 0;

  bit           p_bekliyor = 0;
  logic [31:0]  p_adres = '0, p_veri = '0;
  logic         p_yaz = 0;

  initial begin
    forever begin
      bit exp_gecerli;
      @(negedge clk);
      exp_gecerli = m_mesgul && !m_bekle && !m_bitti;
      if (chk_en) begin
        kontrol("musait", anabellek_musait_o, !m_mesgul);
        kontrol("getir_hazir", getir_veri_hazir_o, m_bitti && !m_kim);
        kontrol("bellek_hazir", bellek_veri_hazir_o, m_bitti && m_kim);
        kontrol("ab_gecerli", ab_gecerli_o, exp_gecerli);
        if (exp_gecerli) begin
          kontrol("ab_adres", ab_adres_o, {m_taban[31:4], 4'h0} + 32'(m_vurus * 4));
          kontrol("ab_yaz", ab_yaz_o, m_yaz);
          if (m_yaz) kontrol("ab_yaz_veri", ab_yaz_veri_o, m_wobek[m_vurus*32 +: 32]);
        end
        kontrol("getir_obek", getir_obek_o, m_obek);
        kontrol("bellek_obek", bellek_obek_o, m_obek);
        if (p_bekliyor && !rst_i) begin
          kontrol("stall_gecerli", ab_gecerli_o, 1'b1);
          kontrol("stall_adres", ab_adres_o, p_adres);
          kontrol("stall_yaz", ab_yaz_o, p_yaz);
          kontrol("stall_veri", ab_yaz_veri_o, p_veri);
        end
      end
      p_bekliyor = ab_gecerli_o && !ab_hazir_i;
      p_adres    = ab_adres_o;
      p_yaz      = ab_yaz_o;
      p_veri     = ab_yaz_veri_o;
      if (ab_gecerli_o && ab_hazir_i) begin
        q_adres.push_back(ab_adres_o);
        if (ab_yaz_o) q_yveri.push_back(ab_yaz_veri_o);
      end
      if (getir_veri_hazir_o) begin g_cnt++; q_kim.push_back(0); q_cyc.push_back(cyc); end
      if (bellek_veri_hazir_o) begin b_cnt++; q_kim.push_back(1); q_cyc.push_back(cyc); end
      rd_pending = ab_gecerli_o && ab_hazir_i && !ab_yaz_o;
      rd_adres   = ab_adres_o;
      // advance the model across the coming edge
      if (rst_i) begin
        m_mesgul = 0; m_bekle = 0; m_bitti = 0; m_obek = '0; m_son = 0;
      end else if (!m_mesgul) begin
        if (getir_istek_i || bellek_istek_i) begin
          if (getir_istek_i && bellek_istek_i) m_kim = ADIL ? !m_son : 1'b1;
          else m_kim = bellek_istek_i;
          m_son    = m_kim;
          m_mesgul = 1;
          m_vurus  = 0;
          m_taban  = m_kim ? bellek_adres_i : getir_adres_i;
          m_yaz    = m_kim ? bellek_yaz_i : 1'b0;
          m_wobek  = bellek_yazilacak_obek_i;
        end
      end else if (m_bitti) begin
        m_mesgul = 0; m_bitti = 0;
      end else if (m_bekle) begin
        if (ab_oku_gecerli_i) begin
          m_obek[m_vurus*32 +: 32] = ab_oku_veri_i;
          m_bekle = 0;
          if (m_vurus == 3) m_bitti = 1; else m_vurus++;
        end
      end else if (ab_hazir_i) begin
        if (m_yaz) begin
          if (m_vurus == 3) m_bitti = 1; else m_vurus++;
        end else m_bekle = 1;
      end
    end
  end

  // Word-bus responder: read word one cycle after accept, optional stall on one beat.
  initial begin
    ab_hazir_i = 1'b0; ab_oku_gecerli_i = 1'b0; ab_oku_veri_i = '0;
    forever begin
      @(posedge clk); #2;
      ab_oku_gecerli_i = rd_pending | spur;
      ab_oku_veri_i    = rd_pending ? bellek_kelime(rd_adres) : 32'hDEADBEEF;
      if (ab_gecerli_o && m_vurus == stall_beat && stall_used < stall_len) begin
        ab_hazir_i = 1'b0;
        stall_used++;
      end else ab_hazir_i = 1'b1;
    end
  end

  task automatic tik(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold each enabled request until its own completion pulse, then drop it.
  task automatic sur(input bit g, input bit b);
    int g0, b0, k;
    g0 = g_cnt; b0 = b_cnt;
    for (k = 0; k < 200; k++) begin
      if (g && g_cnt > g0) getir_istek_i = 1'b0;
      if (b && b_cnt > b0) bellek_istek_i = 1'b0;
      if ((!g || g_cnt > g0) && (!b || b_cnt > b0)) break;
      tik(1);
    end
    kontrol("zaman_asimi", k < 200, 1'b1);
  endtask

  localparam logic [127:0] OBEK1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] OBEK5 = 128'h44414444_33363333_22272222_11141111;
  localparam logic [127:0] WOBEK = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  initial begin
    int c0, g0, b0;
    rst_i = 1'b1;
    getir_istek_i = 0; getir_oku_i = 0; getir_yaz_i = 0; getir_adres_i = '0;
    bellek_istek_i = 0; bellek_yaz_i = 0; bellek_adres_i = '0; bellek_yazilacak_obek_i = '0;
    tik(2);
    chk_en = 1'b1;
    kontrol("reset_musait", anabellek_musait_o, 1'b1);
    kontrol("reset_obek", getir_obek_o, '0);
    tik(1); rst_i = 1'b0;
    tik(1);

    // fetch read at 0x1234
    q_adres.delete(); c0 = cyc; b0 = b_cnt;
    getir_adres_i = 32'h0000_1234; getir_oku_i = 1; getir_yaz_i = 1; getir_istek_i = 1;
    sur(1, 0);
    $display("read getir 0x1234: obek=%h", getir_obek_o);
    kontrol("t1_beats", q_adres.size(), 4);
    if (q_adres.size() == 4) begin
      kontrol("t1_a0", q_adres[0], 32'h1230); kontrol("t1_a1", q_adres[1], 32'h1234);
      kontrol("t1_a2", q_adres[2], 32'h1238); kontrol("t1_a3", q_adres[3], 32'h123C);
    end
    kontrol("t1_obek", getir_obek_o, OBEK1);
    kontrol("t1_latency", q_cyc[$] - c0, 9);
    kontrol("t1_no_bellek", b_cnt - b0, 0);

    // memory-stage write with a 2-cycle stall on beat 1 and inputs changed mid-flight
    tik(1);
    q_adres.delete(); q_yveri.delete(); c0 = cyc; b0 = b_cnt;
    stall_beat = 1; stall_len = 2; stall_used = 0;
    bellek_adres_i = 32'h0000_2000; bellek_yaz_i = 1; bellek_yazilacak_obek_i = WOBEK; bellek_istek_i = 1;
    tik(2);
    bellek_yazilacak_obek_i = '0; bellek_adres_i = 32'h000F_FFF0;
    sur(0, 1);
    stall_beat = -1;
    tik(3);
    $display("write bellek 0x2000: beats=%0d pulses=%0d", q_yveri.size(), b_cnt - b0);
    kontrol("t2_words", q_yveri.size(), 4);
    if (q_yveri.size() == 4) begin
      kontrol("t2_w0", q_yveri[0], 32'hAAAAAAAA); kontrol("t2_w1", q_yveri[1], 32'hBBBBBBBB);
      kontrol("t2_w2", q_yveri[2], 32'hCCCCCCCC); kontrol("t2_w3", q_yveri[3], 32'hDDDDDDDD);
      kontrol("t2_a3", q_adres[3], 32'h200C);
    end
    kontrol("t2_pulses", b_cnt - b0, 1);
    kontrol("t2_latency", q_cyc[$] - c0, 7);
    kontrol("t2_obek_kept", bellek_obek_o, OBEK1);

    // spurious read-valid in BOSTA and ISTEK, then a memory-stage read
    bellek_yaz_i = 0;
    spur = 1; tik(1); spur = 0; tik(1);
    bellek_adres_i = 32'h0005_0040; bellek_istek_i = 1; spur = 1;
    tik(1); tik(1); spur = 0;
    sur(0, 1);
    $display("read bellek 0x50040 with spurious valids: obek=%h", bellek_obek_o);
    kontrol("t3_obek", bellek_obek_o, OBEK5);

    // contention: both read in the same cycle
    tik(1);
    c0 = cyc;
    getir_adres_i = 32'h0000_1234; bellek_adres_i = 32'h0005_0040;
    getir_istek_i = 1; bellek_istek_i = 1;
    sur(1, 1);
    $display("contention: first=%0d second=%0d gap=%0d", q_kim[$-1], q_kim[$], q_cyc[$] - q_cyc[$-1]);
    kontrol("t4_first", q_kim[$-1], ADIL ? 0 : 1);
    kontrol("t4_second", q_kim[$], ADIL ? 1 : 0);
    kontrol("t4_first_cyc", q_cyc[$-1] - c0, 9);
    kontrol("t4_gap", q_cyc[$] - q_cyc[$-1], 10);
    kontrol("t4_obek", getir_obek_o, ADIL ? OBEK5 : OBEK1);

    // fetch drops its request in cycle 3 of a read
    tik(1);
    q_adres.delete(); g0 = g_cnt;
    getir_adres_i = 32'h0005_3000; getir_istek_i = 1;
    tik(3); getir_istek_i = 0;
    sur(1, 0);
    $display("read getir dropped early: beats=%0d pulses=%0d", q_adres.size(), g_cnt - g0);
    kontrol("t5_beats", q_adres.size(), 4);
    kontrol("t5_pulse", g_cnt - g0, 1);
    kontrol("t5_obek", getir_obek_o, OBEK5);

    // reset while waiting for beat 2's read word
    tik(1);
    g0 = g_cnt;
    getir_adres_i = 32'h0000_4000; getir_istek_i = 1;
    tik(6); rst_i = 1; getir_istek_i = 0;
    tik(1); rst_i = 0;
    kontrol("t6_musait", anabellek_musait_o, 1'b1);
    kontrol("t6_obek", getir_obek_o, '0);
    kontrol("t6_gecerli", ab_gecerli_o, 1'b0);
    tik(3);
    kontrol("t6_no_pulse", g_cnt - g0, 0);
    getir_adres_i = 32'h0005_0048; getir_istek_i = 1;
    sur(1, 0);
    $display("reset mid-read then read: obek=%h", getir_obek_o);
    kontrol("t6_after", getir_obek_o, OBEK5);
    tik(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
    $finish;
  end

endmodule

// File: doc/anabellek_denetleyici.md
Name: anabellek_denetleyici

Overview:
Main-memory responder for the fetch-stage block interface. It serves the fetch stage and the memory (bellek) stage, accepting 128-bit block read/write requests. Each block is moved as 32-bit beats on the word bus to main memory. It sits between the core's block-request ports and the external memory, and returns assembled blocks with a one-cycle ready pulse.

Parameters:
ADRES_BIT, 32, address width
VERI_BIT, 32, word-bus data width
OBEK_BIT, 128, block width; must be a multiple of VERI_BIT; beat count VURUS = OBEK_BIT/VERI_BIT (default 4)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
getir_istek_i  in  1  fetch request, held until getir_veri_hazir_o
getir_adres_i  in  ADRES_BIT  fetch block address
getir_oku_i  in  1  fetch read strobe
getir_yaz_i  in  1  fetch write strobe; fetch port is read-only, value ignored
getir_veri_hazir_o  out  1  one-cycle completion pulse to fetch
getir_obek_o  out  OBEK_BIT  returned block to fetch
bellek_istek_i  in  1  memory-stage request, held until bellek_veri_hazir_o
bellek_adres_i  in  ADRES_BIT  memory-stage block address
bellek_yaz_i  in  1  1=write block, 0=read block
bellek_yazilacak_obek_i  in  OBEK_BIT  write data
bellek_veri_hazir_o  out  1  one-cycle completion pulse to memory stage
bellek_obek_o  out  OBEK_BIT  returned block to memory stage
anabellek_musait_o  out  1  high only in BOSTA
ab_gecerli_o  out  1  word-bus beat request valid
ab_hazir_i  in  1  word-bus accepts beat
ab_yaz_o  out  1  beat is a write
ab_adres_o  out  ADRES_BIT  beat address {adres[31:4], vurus[1:0], 2'b00}
ab_yaz_veri_o  out  VERI_BIT  write word
ab_oku_gecerli_i  in  1  read word valid
ab_oku_veri_i  in  VERI_BIT  read word

Behaviour:
- Reset is synchronous and active-high on rst_i, with clock clk_i. Reset puts the state in BOSTA and clears vurus, obek_r, the latched address, and the hakem pointer. All outputs are 0 except anabellek_musait_o=1.
- States:
  - BOSTA: the arbiter picks a requester.
    - Fixed priority: bellek over getir.
    - On a grant, latch the requester ID, address (low 4 bits forced to 0), write flag and write block; set vurus=0; go to ISTEK.
  - ISTEK: drive ab_gecerli_o=1 with ab_adres_o/ab_yaz_o. For a write, ab_yaz_veri_o = obek[32*vurus +: 32].
    - Read, ab_hazir_i=1: go to BEKLE.
    - Write, ab_hazir_i=1: if vurus==VURUS-1 go to TAMAM; else vurus++ and stay in ISTEK.
    - ab_gecerli_o and its payload stay stable until ab_hazir_i.
  - BEKLE: ab_gecerli_o=0. When ab_oku_gecerli_i=1, write ab_oku_veri_i into obek_r[32*vurus +: 32]. Then if vurus==VURUS-1 go to TAMAM; else vurus++ and go to ISTEK.
  - TAMAM: pulse veri_hazir_o for exactly one cycle to the granted requester only, then go to BOSTA.
- getir_obek_o = bellek_obek_o = obek_r. Holds until the next read beat overwrites it. Writes leave obek_r unchanged.
- Latency with zero-wait memory (ab_hazir_i=1, read word one cycle after accept), counting from the request sampled in BOSTA at cycle 0:
  - Read: hazir at cycle 9.
  - Write: hazir at cycle 5.
- There is at least one BOSTA cycle between transactions, so back-to-back requests restart arbitration.
- Boundaries:
  - Requester drops istek mid-transaction: the transaction completes and the pulse is still issued.
  - Requester changes address or data mid-transaction: ignored, because values are latched.
  - Both requests arrive in the same cycle: the arbiter rule applies, and the loser waits with musait low.
  - ab_oku_gecerli_i outside BEKLE: ignored.
  - Reset mid-transaction: the beat is abandoned, no hazir pulse, state returns to BOSTA.
  - vurus wraps only via a state exit, never past VURUS-1.

Optional Feature:
ANABELLEK_ADIL_HAKEM_EN
- Defined: round-robin arbitration. A 1-bit son_verilen pointer records the last winner, and on contention the other requester wins. The pointer updates on every grant.
- Undefined: fixed priority, bellek over getir; no pointer register.

Decomposition:
- Package anabellek_paket holds:
  - the state encoding (BOSTA, ISTEK, BEKLE, TAMAM);
  - requester ID constants ISTEKCI_GETIR=0 and ISTEKCI_BELLEK=1;
  - the VURUS derivation function;
  - the 4-bit block-offset constant.
- One sub-module, anabellek_hakem: a 2-input arbiter that contains the optional round-robin pointer, with grant valid/ID outputs.

Test Plan:
- Fetch read at 0x0000_1234, memory returns words 0x11111111, 0x22222222, 0x33333333, 0x44444444. Expected: beat addresses 0x1230, 0x1234, 0x1238, 0x123C; getir_obek_o = 0x44444444_33333333_22222222_11111111; getir_veri_hazir_o pulses at cycle 9 only; bellek_veri_hazir_o stays 0.
- Memory-stage write of 0xDDDD..._AAAA... at 0x2000 with ab_hazir_i stalled for 2 cycles on beat 1. Expected: ab_yaz_veri_o stable during the stall; 4 write beats with the correct words; bellek_veri_hazir_o pulses once; obek_r unchanged.
- Simultaneous getir and bellek read requests:
  - Macro undefined: bellek served first, then getir after one BOSTA cycle.
  - Macro defined, repeated contention: winners alternate.
- rst_i asserted in BEKLE after beat 2. Expected: next cycle is BOSTA, musait=1, no hazir pulse, obek_r=0; a subsequent request completes normally.
- getir_istek_i dropped in cycle 3 of a read. Expected: all 4 beats are still issued and getir_veri_hazir_o still pulses.
- Spurious ab_oku_gecerli_i pulses while in ISTEK and BOSTA. Expected: obek_r unchanged.
